// File: rtl/cache_fsm_burst.sv
// Cache controller FSM: lookup, burst write-back, burst line fill and optional write-around.
// Build macro CACHE_FSM_WRITE_ALLOCATE_EN: defined = write misses allocate, undefined = write misses go around the cache.
module cache_fsm_burst #(
  parameter int WAYS  = 4,
  parameter int BEATS = 16,
  localparam int WAY_W  = $clog2(WAYS),
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  output logic              cpu_ack,
  output logic              busy,
  input  logic              hit,
  input  logic [WAY_W-1:0]  hit_way,
  input  logic [WAY_W-1:0]  victim_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_single,
  input  logic              mem_ready,
  output logic [BEAT_W-1:0] beat,
  output logic [WAY_W-1:0]  way_sel,
  output logic              line_we,
  output logic              tag_we,
  output logic              word_we,
  output logic              set_dirty,
  output logic              lru_update,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_HIT     = 3'd2,
    ST_WB      = 3'd3,
    ST_FILL    = 3'd4,
    ST_WAROUND = 3'd5
  } state_t;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t              state_r, state_s;
  logic [BEAT_W-1:0]   beat_r, beat_s;
  logic [WAY_W-1:0]    way_sel_r, way_sel_s;
  logic                we_r, we_s;
  logic                write_around_s;

`ifdef CACHE_FSM_WRITE_ALLOCATE_EN
  assign write_around_s = 1'b0;
`else
  assign write_around_s = we_r;
`endif

  assign state   = state_r;
  assign beat    = beat_r;
  assign way_sel = way_sel_r;
  assign busy    = (state_r != ST_IDLE);

  // State, beat counter, captured way and captured write flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      beat_r    <= '0;
      way_sel_r <= '0;
      we_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      beat_r    <= beat_s;
      way_sel_r <= way_sel_s;
      we_r      <= we_s;
    end
  end

  // Next-state decode and Moore outputs; line_we, tag_we and write-around ack follow mem_ready
  always_comb begin
    state_s    = state_r;
    beat_s     = beat_r;
    way_sel_s  = way_sel_r;
    we_s       = we_r;
    cpu_ack    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_single = 1'b0;
    line_we    = 1'b0;
    tag_we     = 1'b0;
    word_we    = 1'b0;
    set_dirty  = 1'b0;
    lru_update = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) begin
          state_s = ST_LOOKUP;
          we_s    = cpu_we;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          way_sel_s = hit_way;
          state_s   = ST_HIT;
        end else begin
          way_sel_s = victim_way;
          if (write_around_s) begin
            state_s = ST_WAROUND;
          end else if (victim_valid && victim_dirty) begin
            state_s = ST_WB;
          end else begin
            state_s = ST_FILL;
          end
        end
      end
      ST_HIT: begin
        lru_update = 1'b1;
        cpu_ack    = 1'b1;
        word_we    = we_r;
        set_dirty  = we_r;
        state_s    = ST_IDLE;
      end
      ST_WB: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          if (beat_r == LAST_BEAT) begin
            beat_s  = '0;
            state_s = ST_FILL;
          end else begin
            beat_s  = beat_r + BEAT_W'(1);
          end
        end else begin
          beat_s = beat_r;
        end
      end
      ST_FILL: begin
        mem_req = 1'b1;
        line_we = mem_ready;
        if (mem_ready) begin
          if (beat_r == LAST_BEAT) begin
            tag_we  = 1'b1;
            beat_s  = '0;
            state_s = ST_HIT;
          end else begin
            beat_s  = beat_r + BEAT_W'(1);
          end
        end else begin
          beat_s = beat_r;
        end
      end
      ST_WAROUND: begin
`ifdef CACHE_FSM_WRITE_ALLOCATE_EN
        state_s = ST_IDLE;
`else
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_single = 1'b1;
        cpu_ack    = mem_ready;
        if (mem_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAROUND;
        end
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fsm_burst.sv
// Directed bench for cache_fsm_burst: vector table for hits and reset priority, scripted miss sequences.
module tb_cache_fsm_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, cpu_req, cpu_we, hit, victim_valid, victim_dirty, mem_ready;
  logic [1:0] hit_way, victim_way;
  logic       cpu_ack, busy, mem_req, mem_we, mem_single;
  logic       line_we, tag_we, word_we, set_dirty, lru_update;
  logic [3:0] beat;
  logic [1:0] way_sel;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  cache_fsm_burst #(.WAYS(4), .BEATS(16)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_ack(cpu_ack), .busy(busy), .hit(hit), .hit_way(hit_way),
    .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_single(mem_single), .mem_ready(mem_ready),
    .beat(beat), .way_sel(way_sel), .line_we(line_we), .tag_we(tag_we),
    .word_we(word_we), .set_dirty(set_dirty), .lru_update(lru_update), .state(state)
  );

  typedef struct packed {
    logic       rst, req, we, hit;
    logic [1:0] hway, vway;
    logic       vv, vd, mr;
  } ins_t;

  typedef struct packed {
    logic [2:0] st;
    logic       ack, bsy;
    logic [1:0] ws;
    logic       wwe, sd, lru, mreq, mwe, ms;
    logic [3:0] bt;
    logic       lwe, twe;
  } outs_t;

  typedef struct {
    ins_t  i;
    outs_t o;
  } vec_t;

  function automatic ins_t mi(int rs, int rq, int we, int h, int hw, int vw, int vv, int vd, int mr);
    ins_t r;
    r.rst = rs[0]; r.req = rq[0]; r.we = we[0]; r.hit = h[0];
    r.hway = hw[1:0]; r.vway = vw[1:0];
    r.vv = vv[0]; r.vd = vd[0]; r.mr = mr[0];
    return r;
  endfunction

  // busy is implied by the state: high everywhere but IDLE
  function automatic outs_t mo(int st, int ack, int ws, int wwe, int sd, int lru,
                               int mreq, int mwe, int ms, int bt, int lwe, int twe);
    outs_t r;
    r.st = st[2:0]; r.ack = ack[0]; r.bsy = (st != 0); r.ws = ws[1:0];
    r.wwe = wwe[0]; r.sd = sd[0]; r.lru = lru[0];
    r.mreq = mreq[0]; r.mwe = mwe[0]; r.ms = ms[0];
    r.bt = bt[3:0]; r.lwe = lwe[0]; r.twe = twe[0];
    return r;
  endfunction

  task automatic cyc(input ins_t i, input outs_t e, input string nm);
    outs_t act;
    @(negedge clk);
    reset = i.rst; cpu_req = i.req; cpu_we = i.we; hit = i.hit;
    hit_way = i.hway; victim_way = i.vway;
    victim_valid = i.vv; victim_dirty = i.vd; mem_ready = i.mr;
    #1;
    act = {state, cpu_ack, busy, way_sel, word_we, set_dirty, lru_update,
           mem_req, mem_we, mem_single, beat, line_we, tag_we};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (st/ack/busy/way/wwe/sd/lru/mreq/mwe/msgl/beat/lwe/twe)",
               nm, act, e);
    end
  endtask

  vec_t tbl[9];
  int   wr_alloc;
  ins_t idle_in;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; hit = 1'b0;
    hit_way = 2'd0; victim_way = 2'd0; victim_valid = 1'b0; victim_dirty = 1'b0; mem_ready = 1'b0;
`ifdef CACHE_FSM_WRITE_ALLOCATE_EN
    wr_alloc = 1;
`else
    wr_alloc = 0;
`endif
    idle_in = mi(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // read hit way 2, write hit way 1, then reset beating a request
    tbl[0] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{mi(0, 1, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{mi(0, 1, 1, 1, 2, 0, 0, 0, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3] = '{mi(0, 1, 1, 0, 0, 0, 0, 0, 1), mo(2, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[4] = '{mi(0, 1, 1, 0, 0, 0, 0, 0, 0), mo(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5] = '{mi(0, 0, 0, 1, 1, 0, 0, 0, 0), mo(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0), mo(2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[7] = '{mi(1, 1, 1, 0, 0, 0, 0, 0, 1), mo(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    for (int k = 0; k < 9; k++) begin
      cyc(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));
    end

    // clean miss into way 1 (write when allocating, else read), 5-cycle stall at beat 7
    cyc(mi(0, 1, wr_alloc, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "cm_idle");
    cyc(mi(0, 0, 0, 0, 0, 1, 1, 0, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "cm_lookup");
    for (int b = 0; b < 16; b++) begin
      if (b == 7) begin
        for (int s = 0; s < 5; s++) begin
          cyc(idle_in, mo(4, 0, 1, 0, 0, 0, 1, 0, 0, 7, 0, 0), "fill_stall");
        end
      end
      cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 1), mo(4, 0, 1, 0, 0, 0, 1, 0, 0, b, 1, (b == 15)), "fill_beat");
    end
    cyc(idle_in, mo(2, 1, 1, wr_alloc, wr_alloc, 1, 0, 0, 0, 0, 0, 0), "cm_hit");
    cyc(idle_in, mo(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "cm_done");

    // dirty read miss into way 3: 16 WB beats, 16 FILL beats, ack 34 cycles after request edge
    cyc(mi(0, 1, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "dm_idle");
    cyc(mi(0, 0, 0, 0, 0, 3, 1, 1, 1), mo(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "dm_lookup");
    for (int b = 0; b < 16; b++) begin
      cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 1), mo(3, 0, 3, 0, 0, 0, 1, 1, 0, b, 0, 0), "wb_beat");
    end
    for (int b = 0; b < 16; b++) begin
      cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 1), mo(4, 0, 3, 0, 0, 0, 1, 0, 0, b, 1, (b == 15)), "dm_fill");
    end
    cyc(idle_in, mo(2, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0), "dm_hit");
    cyc(idle_in, mo(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), "dm_done");

    // reset lands during write-back at beat 9
    cyc(mi(0, 1, 0, 0, 0, 0, 0, 0, 0), mo(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_idle");
    cyc(mi(0, 0, 0, 0, 0, 2, 1, 1, 1), mo(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rw_lookup");
    for (int b = 0; b < 9; b++) begin
      cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 1), mo(3, 0, 2, 0, 0, 0, 1, 1, 0, b, 0, 0), "rw_beat");
    end
    cyc(mi(1, 1, 1, 0, 0, 0, 0, 0, 1), mo(3, 0, 2, 0, 0, 0, 1, 1, 0, 9, 0, 0), "rw_rst");
    cyc(idle_in, mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst");

`ifndef CACHE_FSM_WRITE_ALLOCATE_EN
    // write miss with dirty victim still goes around the cache; memory answers after 3 cycles
    cyc(mi(0, 1, 1, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wa_idle");
    cyc(mi(0, 0, 0, 0, 0, 2, 1, 1, 1), mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wa_lookup");
    for (int s = 0; s < 3; s++) begin
      cyc(idle_in, mo(5, 0, 2, 0, 0, 0, 1, 1, 1, 0, 0, 0), "wa_wait");
    end
    cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 1), mo(5, 1, 2, 0, 0, 0, 1, 1, 1, 0, 0, 0), "wa_ack");
    cyc(idle_in, mo(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wa_done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
